// File: rtl/id_ex_operand_stage.sv
// ID/EX pipeline register for the RV32I core.
// Registers decoded fields, forwards EX/MEM and MEM/WB results, drives ALU operands.
module id_ex_operand_stage #(
    parameter int XLEN = 32,
    parameter int RA_W = 5
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            stall,
    input  logic            flush,
    input  logic            id_valid,
    input  logic [XLEN-1:0] id_pc,
    input  logic [XLEN-1:0] id_rs1_data,
    input  logic [XLEN-1:0] id_rs2_data,
    input  logic [XLEN-1:0] id_imm,
    input  logic [RA_W-1:0] id_rs1_addr,
    input  logic [RA_W-1:0] id_rs2_addr,
    input  logic [RA_W-1:0] id_rd_addr,
    input  logic [3:0]      id_alu_control,
    input  logic            id_op1_sel_pc,
    input  logic            id_op2_sel_imm,
    input  logic            id_reg_write,
    input  logic            exm_reg_write,
    input  logic [RA_W-1:0] exm_rd_addr,
    input  logic [XLEN-1:0] exm_result,
    input  logic            mwb_reg_write,
    input  logic [RA_W-1:0] mwb_rd_addr,
    input  logic [XLEN-1:0] mwb_result,
    output logic            ex_valid,
    output logic [XLEN-1:0] ex_op1,
    output logic [XLEN-1:0] ex_op2,
    output logic [3:0]      ex_alu_control,
    output logic [RA_W-1:0] ex_rd_addr,
    output logic            ex_reg_write,
    output logic [XLEN-1:0] ex_pc,
    output logic [XLEN-1:0] ex_store_data
);

    typedef struct packed {
        logic            valid;
        logic            reg_write;
        logic [3:0]      alu_control;
        logic [RA_W-1:0] rd;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic            op1_sel_pc;
        logic            op2_sel_imm;
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] rs1_data;
        logic [XLEN-1:0] rs2_data;
        logic [XLEN-1:0] imm;
    } id_ex_t;

    id_ex_t q;
    logic [XLEN-1:0] fwd1;
    logic [XLEN-1:0] fwd2;

    // Stage register: flush bubbles the control fields, stall holds everything.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= '0;
        end else if (flush) begin
            q.valid       <= 1'b0;
            q.reg_write   <= 1'b0;
            q.alu_control <= 4'b0000;
            q.rd          <= '0;
        end else if (!stall) begin
            q.valid       <= id_valid;
            q.reg_write   <= id_reg_write & id_valid;
            q.alu_control <= id_alu_control;
            q.rd          <= id_rd_addr;
            q.rs1         <= id_rs1_addr;
            q.rs2         <= id_rs2_addr;
            q.op1_sel_pc  <= id_op1_sel_pc;
            q.op2_sel_imm <= id_op2_sel_imm;
            q.pc          <= id_pc;
            q.rs1_data    <= id_rs1_data;
            q.rs2_data    <= id_rs2_data;
            q.imm         <= id_imm;
        end
    end

    function automatic logic [XLEN-1:0] fwd(
        input logic [RA_W-1:0] a,
        input logic [XLEN-1:0] rf
    );
        logic he;
        logic hm;
        logic [XLEN-1:0] r;
        he = exm_reg_write && (exm_rd_addr != '0)
             && (exm_rd_addr == a);
        hm = mwb_reg_write && (mwb_rd_addr != '0)
             && (mwb_rd_addr == a);
        r = rf;
        unique case (1'b1)
            he:        r = exm_result;
            hm & ~he:  r = mwb_result;
            default:   r = rf;
        endcase
        return r;
    endfunction

    // Forwarding re-evaluates every cycle against live EX/MEM and MEM/WB.
    always_comb begin
        fwd1 = fwd(q.rs1, q.rs1_data);
        fwd2 = fwd(q.rs2, q.rs2_data);
    end

    assign ex_op1         = q.op1_sel_pc  ? q.pc  : fwd1;
    assign ex_op2         = q.op2_sel_imm ? q.imm : fwd2;
    assign ex_store_data  = fwd2;
    assign ex_valid       = q.valid;
    assign ex_reg_write   = q.reg_write & q.valid;
    assign ex_alu_control = q.alu_control;
    assign ex_rd_addr     = q.rd;
    assign ex_pc          = q.pc;

endmodule

// File: tb/tb_id_ex_operand_stage.sv
// Self-checking bench for id_ex_operand_stage.
// Directed scenarios followed by randomized traffic against a reference model.
module tb_id_ex_operand_stage;

    logic        clk = 0;
    logic        rst_n, stall, flush, id_valid;
    logic [31:0] id_pc, id_rs1_data, id_rs2_data, id_imm;
    logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
    logic [3:0]  id_alu_control;
    logic        id_op1_sel_pc, id_op2_sel_imm, id_reg_write;
    logic        exm_reg_write, mwb_reg_write;
    logic [4:0]  exm_rd_addr, mwb_rd_addr;
    logic [31:0] exm_result, mwb_result;
    logic        ex_valid, ex_reg_write;
    logic [31:0] ex_op1, ex_op2, ex_pc, ex_store_data;
    logic [3:0]  ex_alu_control;
    logic [4:0]  ex_rd_addr;

    int total = 0;
    int bad = 0;

    // Reference model: the instruction currently held in EX.
    logic        mv, mrw, msp, msi;
    logic [3:0]  mctl;
    logic [4:0]  mrd, mrs1, mrs2;
    logic [31:0] mpc, mr1, mr2, mimm;

    always #5 clk = ~clk;

    id_ex_operand_stage dut (
        .clk(clk), .rst_n(rst_n), .stall(stall), .flush(flush),
        .id_valid(id_valid), .id_pc(id_pc),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data),
        .id_imm(id_imm), .id_rs1_addr(id_rs1_addr),
        .id_rs2_addr(id_rs2_addr), .id_rd_addr(id_rd_addr),
        .id_alu_control(id_alu_control),
        .id_op1_sel_pc(id_op1_sel_pc),
        .id_op2_sel_imm(id_op2_sel_imm),
        .id_reg_write(id_reg_write),
        .exm_reg_write(exm_reg_write), .exm_rd_addr(exm_rd_addr),
        .exm_result(exm_result),
        .mwb_reg_write(mwb_reg_write), .mwb_rd_addr(mwb_rd_addr),
        .mwb_result(mwb_result),
        .ex_valid(ex_valid), .ex_op1(ex_op1), .ex_op2(ex_op2),
        .ex_alu_control(ex_alu_control), .ex_rd_addr(ex_rd_addr),
        .ex_reg_write(ex_reg_write), .ex_pc(ex_pc),
        .ex_store_data(ex_store_data)
    );

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] mfwd(input logic [4:0] a,
                                         input logic [31:0] rf);
        if (a != 0 && exm_reg_write && exm_rd_addr == a)
            return exm_result;
        if (a != 0 && mwb_reg_write && mwb_rd_addr == a)
            return mwb_result;
        return rf;
    endfunction

    task automatic model_reset();
        mv = 0; mrw = 0; msp = 0; msi = 0; mctl = 0;
        mrd = 0; mrs1 = 0; mrs2 = 0;
        mpc = 0; mr1 = 0; mr2 = 0; mimm = 0;
    endtask

    // Advance one clock, updating the model from the inputs seen at the edge.
    task automatic step();
        @(posedge clk);
        if (!rst_n) model_reset();
        else if (flush) begin
            mv = 0; mrw = 0; mctl = 0; mrd = 0;
        end else if (!stall) begin
            mv = id_valid; mrw = id_reg_write && id_valid;
            mctl = id_alu_control; mrd = id_rd_addr;
            mrs1 = id_rs1_addr; mrs2 = id_rs2_addr;
            msp = id_op1_sel_pc; msi = id_op2_sel_imm;
            mpc = id_pc; mr1 = id_rs1_data; mr2 = id_rs2_data;
            mimm = id_imm;
        end
        #1;
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".valid"}, 32'(ex_valid), 32'(mv));
        chk({tag, ".rw"}, 32'(ex_reg_write), 32'(mrw));
        chk({tag, ".ctl"}, 32'(ex_alu_control), 32'(mctl));
        chk({tag, ".rd"}, 32'(ex_rd_addr), 32'(mrd));
        chk({tag, ".pc"}, ex_pc, mpc);
        chk({tag, ".op1"}, ex_op1, msp ? mpc : mfwd(mrs1, mr1));
        chk({tag, ".op2"}, ex_op2, msi ? mimm : mfwd(mrs2, mr2));
        chk({tag, ".sd"}, ex_store_data, mfwd(mrs2, mr2));
    endtask

    task automatic clr_inputs();
        stall = 0; flush = 0; id_valid = 0;
        id_pc = 0; id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_rs1_addr = 0; id_rs2_addr = 0; id_rd_addr = 0;
        id_alu_control = 0; id_op1_sel_pc = 0; id_op2_sel_imm = 0;
        id_reg_write = 0;
        exm_reg_write = 0; exm_rd_addr = 0; exm_result = 0;
        mwb_reg_write = 0; mwb_rd_addr = 0; mwb_result = 0;
    endtask

    task automatic load_add(input logic [4:0] r1, input logic [31:0] d1,
                            input logic [4:0] r2, input logic [31:0] d2,
                            input logic [4:0] rd);
        id_valid = 1; id_reg_write = 1; id_alu_control = 4'b0000;
        id_rs1_addr = r1; id_rs1_data = d1;
        id_rs2_addr = r2; id_rs2_data = d2; id_rd_addr = rd;
        id_op1_sel_pc = 0; id_op2_sel_imm = 0;
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".valid"}, 32'(ex_valid), 0);
        chk({tag, ".rw"}, 32'(ex_reg_write), 0);
        chk({tag, ".ctl"}, 32'(ex_alu_control), 0);
        chk({tag, ".rd"}, 32'(ex_rd_addr), 0);
        chk({tag, ".pc"}, ex_pc, 0);
        chk({tag, ".op1"}, ex_op1, 0);
        chk({tag, ".op2"}, ex_op2, 0);
        chk({tag, ".sd"}, ex_store_data, 0);
    endtask

    initial begin
        clr_inputs();
        model_reset();
        rst_n = 0;
        #3;
        chk_zero("reset");
        #9 rst_n = 1;

        // Plain capture
        load_add(5'd1, 32'd5, 5'd2, 32'd7, 5'd3);
        step();
        chk("cap.op1", ex_op1, 32'd5);
        chk("cap.op2", ex_op2, 32'd7);
        chk("cap.rd", 32'(ex_rd_addr), 32'd3);
        chk("cap.rw", 32'(ex_reg_write), 1);
        chk("cap.valid", 32'(ex_valid), 1);

        // Reset mid-operation, between edges
        #2 rst_n = 0;
        #1 chk_zero("midrst");
        model_reset();
        #3 rst_n = 1;

        // Double hazard priority
        load_add(5'd4, 32'h99, 5'd2, 32'd7, 5'd5);
        step();
        exm_reg_write = 1; exm_rd_addr = 4; exm_result = 32'h11;
        mwb_reg_write = 1; mwb_rd_addr = 4; mwb_result = 32'h22;
        #1 chk("dh.exm", ex_op1, 32'h11);
        exm_reg_write = 0;
        #1 chk("dh.mwb", ex_op1, 32'h22);
        mwb_reg_write = 0;

        // x0 never forwarded
        load_add(5'd1, 32'd1, 5'd0, 32'd0, 5'd6);
        step();
        exm_reg_write = 1; exm_rd_addr = 0; exm_result = 32'hDEAD;
        #1;
        chk("x0.op2", ex_op2, 0);
        chk("x0.sd", ex_store_data, 0);

        // PC / immediate select with forwarding active
        load_add(5'd5, 32'h33, 5'd6, 32'h77, 5'd7);
        id_op1_sel_pc = 1; id_pc = 32'h100;
        id_op2_sel_imm = 1; id_imm = 32'hFFFFFFFC;
        step();
        exm_reg_write = 1; exm_rd_addr = 6; exm_result = 32'h55;
        mwb_reg_write = 1; mwb_rd_addr = 5; mwb_result = 32'h66;
        #1;
        chk("sel.op1", ex_op1, 32'h100);
        chk("sel.op2", ex_op2, 32'hFFFFFFFC);
        chk("sel.sd", ex_store_data, 32'h55);
        clr_inputs();

        // Stall for three cycles, forwarding tracks exm_result
        load_add(5'd7, 32'h1234, 5'd8, 32'h5678, 5'd9);
        id_alu_control = 4'b0011;
        step();
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            id_rs1_addr = 5'($urandom); id_rd_addr = 5'($urandom);
            id_rs1_data = $urandom; id_alu_control = 4'($urandom);
            exm_reg_write = 1; exm_rd_addr = 7;
            exm_result = 32'hA0 + 32'(i);
            step();
            chk("stall.op1", ex_op1, 32'hA0 + 32'(i));
            chk("stall.rd", 32'(ex_rd_addr), 32'd9);
            chk("stall.ctl", 32'(ex_alu_control), 32'd3);
            chk("stall.valid", 32'(ex_valid), 1);
        end
        flush = 1;
        step();
        chk("flush.valid", 32'(ex_valid), 0);
        chk("flush.rw", 32'(ex_reg_write), 0);
        chk("flush.ctl", 32'(ex_alu_control), 0);
        check_all("flush");
        clr_inputs();

        // Randomized traffic against the model
        for (int n = 0; n < 300; n++) begin
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            id_valid = $urandom_range(0, 1);
            id_reg_write = $urandom_range(0, 1);
            id_alu_control = 4'($urandom_range(0, 7));
            id_rs1_addr = 5'($urandom_range(0, 3));
            id_rs2_addr = 5'($urandom_range(0, 3));
            id_rd_addr = 5'($urandom_range(0, 3));
            id_rs1_data = (id_rs1_addr == 0) ? 0 : $urandom;
            id_rs2_data = (id_rs2_addr == 0) ? 0 : $urandom;
            id_pc = $urandom; id_imm = $urandom;
            id_op1_sel_pc = $urandom_range(0, 1);
            id_op2_sel_imm = $urandom_range(0, 1);
            step();
            exm_reg_write = $urandom_range(0, 1);
            exm_rd_addr = 5'($urandom_range(0, 3));
            exm_result = $urandom;
            mwb_reg_write = $urandom_range(0, 1);
            mwb_rd_addr = 5'($urandom_range(0, 3));
            mwb_result = $urandom;
            #1 check_all("rnd");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/id_ex_operand_stage.md
Name: id_ex_operand_stage

Overview:
- ID/EX pipeline register for the RV32I core, directly upstream of the ALU.
- Captures decoded instruction fields each cycle and holds them on stall; flush turns the slot into a bubble.
- Drives the ALU's op1, op2 and ALU_control from the registered fields, selecting among register-file data, PC, immediate and forwarded results from EX/MEM and MEM/WB.

Parameters:
- XLEN, 32, datapath width.
- RA_W, 5, register-address width.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall  in  1  hold all stage registers.
- flush  in  1  replace captured instruction with a bubble.
- id_valid  in  1  decode slot holds a real instruction.
- id_pc  in  XLEN  instruction PC.
- id_rs1_data  in  XLEN  register-file read data, rs1.
- id_rs2_data  in  XLEN  register-file read data, rs2.
- id_imm  in  XLEN  sign-extended immediate.
- id_rs1_addr  in  RA_W  source register 1 address.
- id_rs2_addr  in  RA_W  source register 2 address.
- id_rd_addr  in  RA_W  destination register address.
- id_alu_control  in  4  ALU operation code (0000 ADD … 0111 SRL).
- id_op1_sel_pc  in  1  1: op1 = PC.
- id_op2_sel_imm  in  1  1: op2 = immediate.
- id_reg_write  in  1  instruction writes rd.
- exm_reg_write  in  1  EX/MEM stage writes rd.
- exm_rd_addr  in  RA_W  EX/MEM destination.
- exm_result  in  XLEN  EX/MEM result.
- mwb_reg_write  in  1  MEM/WB stage writes rd.
- mwb_rd_addr  in  RA_W  MEM/WB destination.
- mwb_result  in  XLEN  MEM/WB result.
- ex_valid  out  1  EX slot valid.
- ex_op1  out  XLEN  ALU op1.
- ex_op2  out  XLEN  ALU op2.
- ex_alu_control  out  4  ALU_control.
- ex_rd_addr  out  RA_W  registered rd.
- ex_reg_write  out  1  registered reg_write, gated by valid.
- ex_pc  out  XLEN  registered PC.
- ex_store_data  out  XLEN  forwarded rs2 value (store data).

Behaviour:
- Reset (rst_n low, asynchronous):
  - All stage registers and all registered outputs go to 0: ex_valid=0, ex_reg_write=0, ex_alu_control=0000, ex_rd_addr=0, ex_pc=0.
  - ex_op1, ex_op2 and ex_store_data read 0 while in reset.
  - Deassertion takes effect at the next rising edge.
- Capture priority at each rising clk:
  - flush=1 (wins over stall): valid=0, reg_write=0, alu_control=0000, rd=0; data fields are don't-care but held at their current value.
  - else stall=1: every register holds.
  - else: all id_* fields are loaded. Stored reg_write = id_reg_write & id_valid.
- Latency: one cycle from id_* to registered fields. Operand outputs are combinational from the registered fields plus the exm_*/mwb_* inputs, so the ALU sees them in the same cycle.
- Forwarding, evaluated independently for rs1 and rs2:
  - Use exm_result if exm_reg_write=1, exm_rd_addr≠0 and exm_rd_addr = registered rs address.
  - Otherwise use mwb_result if mwb_reg_write=1, mwb_rd_addr≠0 and the address matches.
  - Otherwise use the registered rf data.
  - EX/MEM has priority when both stages match.
  - x0 is never forwarded; a source address of 0 always yields the registered data, which is 0 from the register file.
- Operand muxes:
  - ex_op1 = PC if op1_sel_pc, else forwarded rs1.
  - ex_op2 = imm if op2_sel_imm, else forwarded rs2.
  - ex_store_data = forwarded rs2, regardless of op2_sel_imm.
- During stall, forwarding keeps re-evaluating each cycle against the live exm_*/mwb_* inputs. The held instruction therefore picks up results that retire while it waits.
- ex_valid=0: the operand outputs still follow the muxes and are don't-care downstream. ex_reg_write is guaranteed 0.
- No internal hazard detection. Load-use stalls are produced externally via stall/flush.

Test Plan:
- Reset mid-operation: load valid ADD (rs1=x1=5, rs2=x2=7), then pull rst_n low between edges → all outputs 0 immediately, ex_alu_control=0000.
- Plain capture: id_valid=1, rs1_data=5, rs2_data=7, alu_control=0000, rd=3, reg_write=1 → next cycle ex_op1=5, ex_op2=7, ex_rd_addr=3, ex_reg_write=1, ex_valid=1.
- Double-hazard priority: registered rs1=x4; exm_rd=4/result=0x11, mwb_rd=4/result=0x22, both writing → ex_op1=0x11. Drop exm_reg_write → ex_op1=0x22.
- x0 guard: rs2=x0, rs2_data=0, exm_rd=0 with reg_write=1 and result=0xDEAD → ex_op2=0, ex_store_data=0.
- Immediate/PC select: op1_sel_pc=1, pc=0x100, op2_sel_imm=1, imm=0xFFFFFFFC, exm forwarding rs1 and rs2 → ex_op1=0x100, ex_op2=0xFFFFFFFC, ex_store_data=forwarded rs2.
- Stall then flush:
  - Hold stall=1 for 3 cycles while new id_* changes → ex fields unchanged; exm_result change on matching rd is reflected in ex_op1.
  - Assert stall=1 and flush=1 together → next cycle ex_valid=0, ex_reg_write=0, ex_alu_control=0000.
